pencoder_rr_nx: RTL and testbench
=================================

PENCODER_RR_NX -- requirements
Module: pencoder_rr_nx

Interface
REQ-001 Parameter N, default 8, number of request inputs; SHALL be a power of two, 2..64.
REQ-002 Parameter W, default $clog2(N), index width; derived, SHALL NOT be overridden.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  N  request vector; bit i set = input i requesting.
REQ-006 mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 out_ready  input  1  downstream accepts current output this cycle.
REQ-008 out_idx  output  W  registered index of the winning request.
REQ-009 out_valid  output  1  out_idx holds a valid encoded request.
REQ-010 out_onehot  output  N  registered one-hot of out_idx; all-zero when out_valid=0.

Function
REQ-011 Handshake: transfer occurs in a cycle with out_valid=1 and out_ready=1.
REQ-012 Load condition: out_valid=0, or a transfer occurs; otherwise out_idx/out_onehot/out_valid SHALL hold unchanged, whatever req does.
REQ-013 On a load, req and mode SHALL be sampled that cycle; the result appears one cycle later (latency 1).
REQ-014 On a load with req=0: out_valid=0, out_onehot=0, out_idx=0.
REQ-015 Fixed mode: the winner is the highest set index of req.
REQ-016 Round-robin mode: the search starts at pointer ptr, ascends through ptr+1 ... N-1, wraps to 0 ... ptr-1; the first set bit wins.
REQ-017 ptr is W bits and resets to 0.
REQ-018 ptr update: only on a transfer while mode=1; ptr <= out_idx+1 mod N, wrapping N-1 -> 0.
REQ-019 ptr SHALL hold in fixed mode and on cycles without a transfer.
REQ-020 A mode change SHALL take effect only at the next load; a held output is never re-encoded.
REQ-021 Back-to-back: with out_ready held high and requests present, one transfer SHALL occur every cycle.
REQ-022 A request deasserted while its index is held SHALL NOT invalidate the held output.
REQ-023 Effective states: EMPTY (out_valid=0), HOLD (out_valid=1, out_ready=0), STREAM (out_valid=1, out_ready=1).
REQ-024 EMPTY -> HOLD/STREAM when the sampled req is nonzero.
REQ-025 HOLD -> HOLD while out_ready=0.
REQ-026 STREAM -> next load; returns to EMPTY if the sampled req=0.

Reset
REQ-027 While rst_n=0, asynchronously: out_valid=0, out_idx=0, out_onehot=0, ptr=0.
REQ-028 Reset asserted mid-HOLD SHALL drop the held output without a transfer.
REQ-029 The first load after reset release SHALL occur on the first rising edge with rst_n=1.

Structure
REQ-030 Shared package pencoder_pkg SHALL hold the MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
REQ-031 The combinational search SHALL be a sub-module pencoder_search, parametrised by N, with these ports:
- inputs req, start, mode
- outputs idx, found
REQ-032 pencoder_rr_nx SHALL contain only the output register, the ptr register and the load logic.

Verification (N=8)
REQ-033 Fixed, req=8'b0010_0110, out_ready=1 -> next cycle out_idx=5, out_onehot=8'b0010_0000, out_valid=1; ptr stays 0.
REQ-034 RR, req=8'hFF held, out_ready=1 for 10 cycles -> out_idx sequence 0,1,...,7,0,1; ptr wraps 7->0.
REQ-035 RR, ptr=6, req=8'b0000_0101 -> out_idx=0; after transfer ptr=1, next out_idx=2.
REQ-036 Stall: out_idx=3 valid, out_ready=0 for 4 cycles while req changes to 8'h80 and mode toggles -> out_idx stays 3, ptr unchanged.
REQ-037 req=0 with out_ready=1 -> out_valid=0, out_onehot=0 the next cycle.
REQ-038 rst_n pulsed low mid-HOLD -> outputs are 0 immediately (asynchronous) and ptr=0; after release with req=8'h10 -> out_idx=4 one cycle later.

Source files
------------

// File: rtl/pencoder_pkg.sv
// Shared constants for the priority / round-robin encoder.
package pencoder_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/pencoder_search.sv
// Combinational winner search: highest set index (fixed) or first set bit
// ascending from start with wrap (round-robin).
module pencoder_search
  import pencoder_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] pos;

  always_comb begin
    idx   = '0;
    pos   = '0;
    found = |req;
    if (mode == MODE_RR) begin
      // Scan offsets downward so the smallest offset from start wins last.
      // N is a power of two, so W-bit addition wraps at N for free.
      for (int k = N - 1; k >= 0; k--) begin
        pos = start + W'(k);
        if (req[pos]) idx = pos;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/pencoder_rr_nx.sv
// Registered priority encoder with valid/ready output and round-robin pointer.
module pencoder_rr_nx
  import pencoder_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  output logic [N-1:0] out_onehot
);

  logic [W-1:0] ptr, ptr_nxt, win_idx;
  logic         win_found, xfer, load;

  assign xfer = out_valid & out_ready;
  assign load = ~out_valid | xfer;

  // The search sees the pointer as already advanced past the index being
  // transferred, so back-to-back round-robin loads rotate every cycle.
  assign ptr_nxt = (xfer && mode == MODE_RR) ? out_idx + W'(1) : ptr;

  pencoder_search #(.N(N), .W(W)) u_search (
    .req   (req),
    .start (ptr_nxt),
    .mode  (mode),
    .idx   (win_idx),
    .found (win_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
    end else begin
      ptr <= ptr_nxt;
      if (load) begin
        out_valid  <= win_found;
        out_idx    <= win_found ? win_idx : '0;
        out_onehot <= win_found ? (N'(1) << win_idx) : '0;
      end
    end
  end

endmodule

// File: tb/tb_pencoder_rr_nx.sv
// Randomized + directed bench for pencoder_rr_nx against a behavioural model.
module tb_pencoder_rr_nx;
  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         mode;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_valid;
  logic [N-1:0] out_onehot;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int m_valid = 0;
  int m_idx   = 0;
  int m_ptr   = 0;

  always #5 clk = ~clk;

  pencoder_rr_nx #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mode       (mode),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_valid  (out_valid),
    .out_onehot (out_onehot)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int winner(input logic [N-1:0] r, input logic md, input int p);
    int w = -1;
    if (!md) begin
      for (int i = 0; i < N; i++) if (r[i]) w = i;
    end else begin
      for (int k = 0; k < N; k++)
        if (w < 0 && r[(p + k) % N]) w = (p + k) % N;
    end
    return w;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_idx = 0; m_ptr = 0;
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] oh;
    oh = m_valid ? N'(1 << m_idx) : '0;
    chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".idx"}, 64'(out_idx), 64'(m_idx));
    chk({tag, ".onehot"}, 64'(out_onehot), 64'(oh));
  endtask

  // Drive one cycle, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic [N-1:0] r, input logic md, input logic rdy, input string tag);
    int w;
    bit tx;
    req = r; mode = md; out_ready = rdy;
    tx = (m_valid != 0) && rdy;
    if (tx && md) m_ptr = (m_idx + 1) % N;
    if (m_valid == 0 || tx) begin
      w = winner(r, md, m_ptr);
      m_valid = (w >= 0);
      m_idx   = (w >= 0) ? w : 0;
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; mode = 1'b0; out_ready = 1'b0;
    model_reset();
    #12;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.idx", 64'(out_idx), 64'd0);
    chk("rst.onehot", 64'(out_onehot), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Fixed priority picks highest index
    step(8'b0010_0110, 1'b0, 1'b1, "fixed");
    chk("fixed.idx5", 64'(out_idx), 64'd5);
    chk("fixed.oh", 64'(out_onehot), 64'h20);

    // Transfer with empty request drains
    step(8'h00, 1'b0, 1'b1, "empty");
    chk("empty.valid", 64'(out_valid), 64'd0);

    // Round-robin rotation; ptr stayed 0 through fixed mode
    for (int i = 0; i < 10; i++) begin
      step(8'hFF, 1'b1, 1'b1, "rr_ff");
      chk("rr_seq", 64'(out_idx), 64'(i % N));
    end

    // Drive ptr to 6, then wrap search
    step(8'h20, 1'b1, 1'b1, "rr_to5");
    step(8'b0000_0101, 1'b1, 1'b1, "rr_p6");
    chk("rr_p6.idx0", 64'(out_idx), 64'd0);
    step(8'b0000_0101, 1'b1, 1'b1, "rr_p1");
    chk("rr_p1.idx2", 64'(out_idx), 64'd2);

    // Stall: held output survives req/mode churn
    step(8'h08, 1'b1, 1'b1, "rr_to3");
    for (int i = 0; i < 4; i++) begin
      step(8'h80, i[0], 1'b0, "stall");
      chk("stall.idx3", 64'(out_idx), 64'd3);
    end
    step(8'hFF, 1'b1, 1'b1, "post_stall");
    chk("post_stall.idx4", 64'(out_idx), 64'd4);

    // Async reset mid-hold
    step(8'h01, 1'b1, 1'b0, "hold");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst.valid", 64'(out_valid), 64'd0);
    chk("async_rst.idx", 64'(out_idx), 64'd0);
    chk("async_rst.onehot", 64'(out_onehot), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    step(8'h10, 1'b1, 1'b1, "after_rst");
    chk("after_rst.idx4", 64'(out_idx), 64'd4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      int sel;
      sel = $urandom_range(0, 7);
      r = N'($urandom);
      if (sel == 0) r = '0;
      else if (sel < 4) r = r & N'($urandom) & N'($urandom);
      step(r, 1'($urandom), ($urandom_range(0, 9) < 7), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
